// File: rtl/dec_gpr_ctx_ctl.sv
// GPR bank context controller: saves one register-file bank out to a stream
// or restores it from a stream, moving x1..x31 and never touching x0.
module dec_gpr_ctx_ctl #(
    parameter int GPR_BANKS      = 1,
    parameter int GPR_BANKS_LOG2 = 1
) (
    input  logic                      clk,
    input  logic                      rst_l,

    input  logic                      save_req,
    input  logic                      restore_req,
    input  logic [GPR_BANKS_LOG2-1:0] req_bank,
    input  logic                      abort,
    output logic                      busy,
    output logic                      done,
    output logic                      err,

    output logic                      gpr_wen_bank_id,
    output logic [GPR_BANKS_LOG2-1:0] gpr_wr_bank_id,
    output logic                      gpr_rden,
    output logic [4:0]                gpr_raddr,
    input  logic [31:0]               gpr_rdata,
    output logic                      gpr_wen,
    output logic [4:0]                gpr_waddr,
    output logic [31:0]               gpr_wdata,

    output logic                      so_valid,
    input  logic                      so_ready,
    output logic [31:0]               so_data,
    output logic                      so_last,

    input  logic                      si_valid,
    output logic                      si_ready,
    input  logic [31:0]               si_data,
    input  logic                      si_last,

    output logic [2:0]                state_dbg
);

    // Streams use valid/ready: a beat transfers on a rising edge where both are
    // high; the producer holds data/last stable while valid=1 and ready=0.

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_BANKSEL = 3'd1;
    localparam logic [2:0] ST_SAVE    = 3'd2;
    localparam logic [2:0] ST_RESTORE = 3'd3;
    localparam logic [2:0] ST_FIN     = 3'd4;

    localparam logic [4:0] IDX_FIRST = 5'd1;
    localparam logic [4:0] IDX_LAST  = 5'd31;

    if (GPR_BANKS > (1 << GPR_BANKS_LOG2)) begin : g_bank_width_chk
        $error("GPR_BANKS does not fit in GPR_BANKS_LOG2 bits");
    end

    logic [2:0]                state_q, state_d;
    logic [4:0]                idx_q, idx_d;
    logic [GPR_BANKS_LOG2-1:0] bank_q, bank_d;
    logic                      err_q, err_d;
    logic                      save_mode_q, save_mode_d;

    logic so_hs;
    logic si_hs;
    logic at_last;

    assign so_hs   = (state_q == ST_SAVE) && so_ready;
    assign si_hs   = (state_q == ST_RESTORE) && si_valid;
    assign at_last = (idx_q == IDX_LAST);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        bank_d      = bank_q;
        err_d       = err_q;
        save_mode_d = save_mode_q;

        case (state_q)
            ST_IDLE: begin
                // Save wins when both requests arrive together.
                if (save_req || restore_req) begin
                    state_d     = ST_BANKSEL;
                    save_mode_d = save_req;
                    bank_d      = req_bank;
                    err_d       = 1'b0;
                    idx_d       = IDX_FIRST;
                end
            end

            ST_BANKSEL: begin
                state_d = save_mode_q ? ST_SAVE : ST_RESTORE;
                if (abort) begin
                    err_d   = 1'b1;
                    state_d = ST_FIN;
                end
            end

            ST_SAVE: begin
                if (so_hs) begin
                    if (at_last) begin
                        state_d = ST_FIN;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
                if (abort) begin
                    err_d   = 1'b1;
                    state_d = ST_FIN;
                end
            end

            ST_RESTORE: begin
                // A beat is always written; last-marker disagreement with the
                // index only flags the error and ends the transfer.
                if (si_hs) begin
                    if (at_last) begin
                        state_d = ST_FIN;
                        if (!si_last) begin
                            err_d = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + 5'd1;
                        if (si_last) begin
                            err_d   = 1'b1;
                            state_d = ST_FIN;
                        end
                    end
                end
                if (abort) begin
                    err_d   = 1'b1;
                    state_d = ST_FIN;
                end
            end

            ST_FIN: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q     <= ST_IDLE;
            idx_q       <= 5'd0;
            bank_q      <= '0;
            err_q       <= 1'b0;
            save_mode_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            bank_q      <= bank_d;
            err_q       <= err_d;
            save_mode_q <= save_mode_d;
        end
    end

    // Outputs decode from registered state only, so reset clears them at once.
    always_comb begin
        busy            = (state_q != ST_IDLE);
        done            = (state_q == ST_FIN);
        err             = err_q;
        gpr_wen_bank_id = 1'b0;
        gpr_wr_bank_id  = '0;
        gpr_rden        = 1'b0;
        gpr_raddr       = 5'd0;
        gpr_wen         = 1'b0;
        gpr_waddr       = 5'd0;
        gpr_wdata       = 32'd0;
        so_valid        = 1'b0;
        so_data         = 32'd0;
        so_last         = 1'b0;
        si_ready        = 1'b0;

        case (state_q)
            ST_BANKSEL: begin
                gpr_wen_bank_id = 1'b1;
                gpr_wr_bank_id  = bank_q;
            end
            ST_SAVE: begin
                gpr_rden  = 1'b1;
                gpr_raddr = idx_q;
                so_valid  = 1'b1;
                so_data   = gpr_rdata;
                so_last   = at_last;
            end
            ST_RESTORE: begin
                si_ready = 1'b1;
                if (si_valid) begin
                    gpr_wen   = 1'b1;
                    gpr_waddr = idx_q;
                    gpr_wdata = si_data;
                end
            end
            default: begin
            end
        endcase
    end

    assign state_dbg = state_q;

endmodule

// File: doc/dec_gpr_ctx_ctl.md
DEC_GPR_CTX_CTL -- requirements
Module: dec_gpr_ctx_ctl

Interface
REQ-001 Parameter GPR_BANKS, default 1, number of GPR banks in the register file.
REQ-002 Parameter GPR_BANKS_LOG2, default 1, width of bank id.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_l  input  1  asynchronous active-low reset.
REQ-005 save_req  input  1  start bank save (register file to stream), sampled in IDLE only.
REQ-006 restore_req  input  1  start bank restore (stream to register file), sampled in IDLE only.
REQ-007 req_bank  input  GPR_BANKS_LOG2  target bank, captured with the accepted request.
REQ-008 abort  input  1  terminate the active operation.
REQ-009 busy  output  1  high in any state other than IDLE.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 err  output  1  sticky error flag; cleared when the next request is accepted.
REQ-012 gpr_wen_bank_id  output  1  bank-select write strobe to the register file.
REQ-013 gpr_wr_bank_id  output  GPR_BANKS_LOG2  bank id to load.
REQ-014 gpr_rden  output  1  register-file read enable.
REQ-015 gpr_raddr  output  5  register-file read address.
REQ-016 gpr_rdata  input  32  register-file read data, combinational from gpr_raddr.
REQ-017 gpr_wen  output  1  register-file write enable.
REQ-018 gpr_waddr  output  5  register-file write address.
REQ-019 gpr_wdata  output  32  register-file write data.
REQ-020 so_valid, so_ready, so_data[31:0], so_last  output/input/output/output  save stream (valid/ready).
REQ-021 si_valid, si_ready, si_data[31:0], si_last  input/output/input/input  restore stream (valid/ready).

Function
REQ-022 The FSM SHALL have states IDLE, BANKSEL, SAVE, RESTORE and FIN, plus a 5-bit index register idx.
REQ-023 In IDLE, save_req=1 SHALL go to BANKSEL in save mode; save SHALL win when save_req and restore_req are high together.
REQ-024 In IDLE, restore_req=1 with save_req=0 SHALL go to BANKSEL in restore mode.
REQ-025 On request accept: req_bank captured, err cleared, idx set to 1.
REQ-026 BANKSEL SHALL last exactly one cycle with gpr_wen_bank_id=1 and gpr_wr_bank_id=captured bank, then go to SAVE or RESTORE.
REQ-027 In SAVE: gpr_rden=1, gpr_raddr=idx, so_valid=1, so_data=gpr_rdata, so_last=(idx==31).
REQ-028 In SAVE, so_data/so_last SHALL be held stable while so_valid=1 and so_ready=0.
REQ-029 In SAVE, each so_valid&so_ready beat SHALL increment idx; the beat with idx==31 SHALL go to FIN.
REQ-030 In RESTORE: si_ready=1, and each si_valid beat drives gpr_wen=1, gpr_waddr=idx, gpr_wdata=si_data in the same cycle, then increments idx.
REQ-031 Register x0 SHALL never be read or written; a save or restore moves exactly 31 words (x1..x31).
REQ-032 A restore beat with si_last=1 and idx<31 SHALL be written, set err, and go to FIN.
REQ-033 The idx==31 restore beat with si_last=0 SHALL be written, set err, and go to FIN.
REQ-034 idx SHALL never wrap past 31.
REQ-035 abort=1 in BANKSEL/SAVE/RESTORE SHALL set err and go to FIN next cycle; a handshake beat in that cycle SHALL still complete.
REQ-036 FIN SHALL assert done=1 for one cycle and return to IDLE.
REQ-037 Requests in any state other than IDLE SHALL be ignored (no queuing).
REQ-038 Outside its owning state, each strobe/valid/ready output SHALL be 0 and address/data outputs SHALL be 0.
REQ-039 Minimum latency: save with so_ready held high is 1+31+1 = 33 cycles from accept to done.

Reset
REQ-040 rst_l=0 SHALL immediately force IDLE, idx=0, err=0, and all outputs 0, including mid-operation.
REQ-041 After rst_l deasserts, the first request SHALL be accepted no earlier than the first rising clk edge.

Verification
REQ-042 Save bank 0, x1..x31 = 0x100+n, so_ready=1 -> 1 bank strobe; 31 beats of 0x101..0x11F; so_last only on beat 31; done 33 cycles after accept; err=0.
REQ-043 Save with so_ready toggling 1/0 -> data held during stalls; 31 beats in order; done after 62 handshake-phase cycles.
REQ-044 Restore bank 1, words 0xA0000001..0xA000001F, si_last on beat 31 -> gpr_wr_bank_id=1; 31 writes to x1..x31 with matching data; err=0.
REQ-045 Restore with si_last on beat 10 -> x1..x10 written, err=1, done; x11..x31 untouched.
REQ-046 save_req and restore_req together in IDLE -> save performed; requests issued while busy -> ignored.
REQ-047 abort on beat 5 of a save, and rst_l pulsed low mid-restore -> abort gives err=1 and done one cycle later; reset forces all outputs 0 and IDLE asynchronously.
